instr_mem_loader: RTL and testbench

//  Program memory and loader directly upstream of the Microprocessor core.

---
 rtl/instr_mem_loader_pkg.sv | 19 +
 rtl/instr_mem_loader_if.sv | 19 +
 rtl/instr_mem_loader_array.sv | 24 ++
 rtl/instr_mem_loader.sv | 173 +++++++++++++++++
 tb/tb_instr_mem_loader.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the instruction memory loader.
//  - state_e   : loader FSM encoding (3 bits)
//  - CLEAR_FILL_DEF : default word written across the store during CLEAR
//  - CSUM_W    : width of the modulo-256 program checksum
package instr_mem_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LOAD  = 3'd2,
    S_CHECK = 3'd3,
    S_RUN   = 3'd4,
    S_ERROR = 3'd5
  } state_e;

  localparam logic [7:0] CLEAR_FILL_DEF = 8'h00;
  localparam int         CSUM_W         = 8;

endpackage

// File: rtl/instr_mem_loader_if.sv
// Byte-stream load channel plus the core's fetch path.
//  load_valid/load_byte/load_ready : program image stream (valid/ready)
//  pc/instruction                  : core fetch address and returned word
// master = image source / core side, slave = loader.
interface instr_mem_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              load_valid;
  logic [7:0]        load_byte;
  logic              load_ready;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] instruction;

  modport master (output load_valid, load_byte, pc,
                  input  load_ready, instruction);
  modport slave  (input  load_valid, load_byte, pc,
                  output load_ready, instruction);
endinterface

// File: rtl/instr_mem_loader_array.sv
// instr_mem_array: DEPTH x DATA_W storage, one synchronous write port and one
// asynchronous read port. Contents are never reset.
//  clk   : write clock
//  we/waddr/wdata : write port
//  raddr/rdata    : combinational read port
module instr_mem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: program store and loader in front of the core.
// Clears the store, fills it from a length-prefixed byte stream, holds the
// core in reset meanwhile, then serves instruction = mem[pc] in RUN.
//  origclk, reset      : clock, synchronous active-high reset
//  load_start, run_req : start a load (any state) / run existing contents (IDLE)
//  bus (slave)         : load stream and core fetch path
//  cpu_reset           : registered core reset
//  busy                : CLEAR or LOAD in progress
//  load_error          : sticky checksum failure
//  load_count          : program bytes written by the current/last load
// Optional: define CHECKSUM_EN to append a checksum byte and CHECK/ERROR states.
module instr_mem_loader
  import instr_mem_pkg::*;
#(
  parameter int               ADDR_W     = 8,
  parameter int               DATA_W     = 8,
  parameter logic [DATA_W-1:0] CLEAR_FILL = DATA_W'(CLEAR_FILL_DEF)
) (
  input  logic              origclk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              run_req,
  instr_mem_loader_if.slave bus,
  output logic              cpu_reset,
  output logic              busy,
  output logic              load_error,
  output logic [ADDR_W:0]   load_count
);
  localparam int              DEPTH   = 2**ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   count_q, count_d, count_inc;
  logic              have_len_q, have_len_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              ready, accept;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata, rdata;
`ifdef CHECKSUM_EN
  logic [CSUM_W-1:0] sum_q, sum_d;
  logic              err_q, err_d;
`endif

  assign count_inc = count_q + (ADDR_W+1)'(1);
  assign accept    = bus.load_valid && ready;

  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    len_d       = len_q;
    count_d     = count_q;
    have_len_d  = have_len_q;
    we          = 1'b0;
    waddr       = count_q[ADDR_W-1:0];
    wdata       = DATA_W'(bus.load_byte);
`ifdef CHECKSUM_EN
    sum_d       = sum_q;
    err_d       = err_q;
    ready       = (state_q == S_LOAD) || (state_q == S_CHECK);
`else
    ready       = (state_q == S_LOAD);
`endif

    case (state_q)
      S_IDLE: if (run_req) state_d = S_RUN;
      S_CLEAR: begin
        we         = 1'b1;
        waddr      = clr_addr_q;
        wdata      = CLEAR_FILL;
        clr_addr_d = clr_addr_q + ADDR_W'(1);
        if (clr_addr_q == '1) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (accept) begin
          if (!have_len_q) begin
            // Length 0 encodes a full-depth image.
            have_len_d = 1'b1;
            len_d      = (bus.load_byte == 8'd0) ? DEPTH_C : (ADDR_W+1)'(bus.load_byte);
          end else begin
            we      = 1'b1;
            count_d = count_inc;
`ifdef CHECKSUM_EN
            sum_d   = sum_q + bus.load_byte;
            if (count_inc == len_q) state_d = S_CHECK;
`else
            if (count_inc == len_q) state_d = S_RUN;
`endif
          end
        end
      end
`ifdef CHECKSUM_EN
      S_CHECK: begin
        if (accept) begin
          if (bus.load_byte == sum_q) state_d = S_RUN;
          else begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end
        end
      end
      S_ERROR: ;
`endif
      S_RUN: ;
      default: state_d = S_IDLE;
    endcase

    // Restart overrides everything; a stray write this cycle is harmless
    // because CLEAR rewrites the whole store.
    if (load_start) begin
      state_d    = S_CLEAR;
      clr_addr_d = '0;
      len_d      = '0;
      count_d    = '0;
      have_len_d = 1'b0;
`ifdef CHECKSUM_EN
      sum_d      = '0;
      err_d      = 1'b0;
`endif
    end

    // Release one cycle after entering RUN; re-assert on the edge that leaves it.
    cpu_reset_d = !((state_q == S_RUN) && (state_d == S_RUN));
  end

  always_ff @(posedge origclk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      clr_addr_q  <= '0;
      len_q       <= '0;
      count_q     <= '0;
      have_len_q  <= 1'b0;
      cpu_reset_q <= 1'b1;
`ifdef CHECKSUM_EN
      sum_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      len_q       <= len_d;
      count_q     <= count_d;
      have_len_q  <= have_len_d;
      cpu_reset_q <= cpu_reset_d;
`ifdef CHECKSUM_EN
      sum_q       <= sum_d;
      err_q       <= err_d;
`endif
    end
  end

  instr_mem_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem (
    .clk   (origclk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (bus.pc),
    .rdata (rdata)
  );

  assign bus.load_ready  = ready;
  assign bus.instruction = (state_q == S_RUN) ? rdata : CLEAR_FILL;
  assign busy            = (state_q == S_CLEAR) || (state_q == S_LOAD);
  assign cpu_reset       = cpu_reset_q;
  assign load_count      = count_q;
`ifdef CHECKSUM_EN
  assign load_error      = err_q;
`else
  assign load_error      = 1'b0;
`endif
endmodule

// File: tb/tb_instr_mem_loader.sv
module tb_instr_mem_loader;
  logic       origclk = 1'b0;
  logic       reset, load_start, run_req;
  logic       cpu_reset, busy, load_error;
  logic [8:0] load_count;
  int         checks = 0;
  int         errors = 0;

  instr_mem_loader_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  instr_mem_loader dut (
    .origclk    (origclk),
    .reset      (reset),
    .load_start (load_start),
    .run_req    (run_req),
    .bus        (bus),
    .cpu_reset  (cpu_reset),
    .busy       (busy),
    .load_error (load_error),
    .load_count (load_count)
  );

  always #5 origclk = ~origclk;

  logic [7:0] img5 [5] = '{8'h44, 8'h49, 8'h19, 8'h84, 8'hC3};

  task automatic tick;
    @(posedge origclk);
    #1;
  endtask

  task automatic pulse_start;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  // Offer one byte after `gap` idle cycles and hold it until accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    bus.load_valid = 1'b0;
    repeat (gap) tick();
    bus.load_valid = 1'b1;
    bus.load_byte  = b;
    n = 0;
    while (bus.load_ready !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) begin
      checks++; errors++;
      $display("FAIL send_timeout byte %h: load_ready never rose", b);
    end
    tick();
    bus.load_valid = 1'b0;
  endtask

  // Checksum byte only exists in the CHECKSUM_EN build.
  task automatic send_csum(input logic [7:0] s);
`ifdef CHECKSUM_EN
    send_byte(s, 0);
`else
    if (s === 8'hxx) $display("unused");
`endif
  endtask

  task automatic test_reset;
    reset = 1'b1; load_start = 1'b0; run_req = 1'b0;
    bus.load_valid = 1'b0; bus.load_byte = 8'h00; bus.pc = 8'h00;
    tick(); tick();
    reset = 1'b0;
    checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL rst_cpu_reset got %b want 1", cpu_reset); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", bus.load_ready); end
    checks++; if (load_error !== 1'b0) begin errors++; $display("FAIL rst_error got %b want 0", load_error); end
    checks++; if (load_count !== 9'd0) begin errors++; $display("FAIL rst_count got %0d want 0", load_count); end
    foreach (img5[i]) begin
      bus.pc = img5[i]; #1;
      checks++; if (bus.instruction !== 8'h00) begin errors++; $display("FAIL rst_instr pc %h got %h want 00", bus.pc, bus.instruction); end
    end
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL run_req_lag got %b want 1", cpu_reset); end
    tick();
    checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL run_req_release got %b want 0", cpu_reset); end
  endtask

  task automatic test_basic_load;
    bus.pc = 8'h00;
    pulse_start();
    checks++; if (cpu_reset !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL clr_enter cpu_reset %b busy %b want 1 1", cpu_reset, busy); end
    checks++; if (bus.instruction !== 8'h00) begin errors++; $display("FAIL clr_instr got %h want 00", bus.instruction); end
    repeat (255) tick();
    checks++; if (bus.load_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL clr_len256 ready %b busy %b want 0 1", bus.load_ready, busy); end
    tick();
    checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL load_enter ready %b want 1", bus.load_ready); end
    send_byte(8'd5, 0);
    foreach (img5[i]) send_byte(img5[i], 0);
    checks++; if (load_count !== 9'd5 || busy !== 1'b0) begin errors++; $display("FAIL basic_done count %0d busy %b want 5 0", load_count, busy); end
    send_csum(8'hED);
    checks++; if (cpu_reset !== 1'b1 || bus.load_ready !== 1'b0) begin errors++; $display("FAIL basic_run cpu_reset %b ready %b want 1 0", cpu_reset, bus.load_ready); end
    tick();
    checks++; if (cpu_reset !== 1'b0 || load_error !== 1'b0) begin errors++; $display("FAIL basic_release cpu_reset %b err %b want 0 0", cpu_reset, load_error); end
    for (int i = 0; i < 6; i++) begin
      bus.pc = 8'(i); #1;
      checks++; if (bus.instruction !== ((i < 5) ? img5[i] : 8'h00)) begin errors++; $display("FAIL basic_instr pc %0d got %h want %h", i, bus.instruction, (i < 5) ? img5[i] : 8'h00); end
    end
    bus.load_valid = 1'b1; bus.load_byte = 8'hAA;
    repeat (3) tick();
    bus.load_valid = 1'b0; bus.pc = 8'h00; #1;
    checks++; if (load_count !== 9'd5 || bus.instruction !== 8'h44) begin errors++; $display("FAIL run_ignore count %0d instr %h want 5 44", load_count, bus.instruction); end
  endtask

  task automatic test_gapped;
    pulse_start();
    bus.load_valid = 1'b1; bus.load_byte = 8'h77;
    repeat (200) tick();
    bus.load_valid = 1'b0;
    checks++; if (load_count !== 9'd0) begin errors++; $display("FAIL clr_valid_ignored count %0d want 0", load_count); end
    send_byte(8'd5, 2);
    foreach (img5[i]) send_byte(img5[i], 2);
    send_csum(8'hED);
    tick();
    checks++; if (load_count !== 9'd5 || cpu_reset !== 1'b0) begin errors++; $display("FAIL gap_done count %0d cpu_reset %b want 5 0", load_count, cpu_reset); end
    for (int i = 0; i < 6; i++) begin
      bus.pc = 8'(i); #1;
      checks++; if (bus.instruction !== ((i < 5) ? img5[i] : 8'h00)) begin errors++; $display("FAIL gap_instr pc %0d got %h want %h", i, bus.instruction, (i < 5) ? img5[i] : 8'h00); end
    end
  endtask

  task automatic test_full_depth;
    pulse_start();
    send_byte(8'd0, 0);
    for (int i = 0; i < 255; i++) send_byte(8'(i), 0);
    checks++; if (load_count !== 9'd255 || bus.load_ready !== 1'b1) begin errors++; $display("FAIL full_255 count %0d ready %b want 255 1", load_count, bus.load_ready); end
    send_byte(8'hFF, 0);
    checks++; if (load_count !== 9'd256 || busy !== 1'b0) begin errors++; $display("FAIL full_done count %0d busy %b want 256 0", load_count, busy); end
    send_csum(8'h80);
    tick();
    checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL full_release got %b want 0", cpu_reset); end
    bus.pc = 8'hFF; #1;
    checks++; if (bus.instruction !== 8'hFF) begin errors++; $display("FAIL full_mem255 got %h want ff", bus.instruction); end
    bus.pc = 8'h80; #1;
    checks++; if (bus.instruction !== 8'h80) begin errors++; $display("FAIL full_mem128 got %h want 80", bus.instruction); end
  endtask

  task automatic test_abort;
    bus.pc = 8'h03; #1;
    checks++; if (bus.instruction !== 8'h03) begin errors++; $display("FAIL abort_pre got %h want 03", bus.instruction); end
    pulse_start();
    checks++; if (cpu_reset !== 1'b1 || busy !== 1'b1 || load_count !== 9'd0) begin errors++; $display("FAIL abort_run cpu_reset %b busy %b count %0d want 1 1 0", cpu_reset, busy, load_count); end
    checks++; if (bus.instruction !== 8'h00) begin errors++; $display("FAIL abort_instr got %h want 00", bus.instruction); end
    send_byte(8'd5, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    checks++; if (load_count !== 9'd2) begin errors++; $display("FAIL abort_partial count %0d want 2", load_count); end
    pulse_start();
    checks++; if (load_count !== 9'd0 || busy !== 1'b1 || bus.load_ready !== 1'b0) begin errors++; $display("FAIL abort_load count %0d busy %b ready %b want 0 1 0", load_count, busy, bus.load_ready); end
    send_byte(8'd5, 0);
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 0);
    send_csum(8'h0F);
    tick();
    bus.pc = 8'h03; #1;
    checks++; if (bus.instruction !== 8'h04) begin errors++; $display("FAIL abort_reload pc3 got %h want 04", bus.instruction); end
    bus.pc = 8'h05; #1;
    checks++; if (bus.instruction !== 8'h00) begin errors++; $display("FAIL abort_cleared pc5 got %h want 00", bus.instruction); end
  endtask

  task automatic test_reset_midload;
    pulse_start();
    send_byte(8'd5, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (busy !== 1'b0 || cpu_reset !== 1'b1 || load_count !== 9'd0) begin errors++; $display("FAIL midrst busy %b cpu_reset %b count %0d want 0 1 0", busy, cpu_reset, load_count); end
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      bus.pc = 8'(i); #1;
      checks++; if (bus.instruction !== ((i == 0) ? 8'hAA : (i == 1) ? 8'hBB : 8'h00)) begin errors++; $display("FAIL midrst_instr pc %0d got %h", i, bus.instruction); end
    end
  endtask

`ifdef CHECKSUM_EN
  task automatic test_checksum;
    pulse_start();
    send_byte(8'd2, 0); send_byte(8'h44, 0); send_byte(8'h49, 0);
    checks++; if (bus.load_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL chk_state ready %b busy %b want 1 0", bus.load_ready, busy); end
    send_byte(8'h8D, 0);
    tick();
    checks++; if (cpu_reset !== 1'b0 || load_error !== 1'b0) begin errors++; $display("FAIL chk_good cpu_reset %b err %b want 0 0", cpu_reset, load_error); end
    pulse_start();
    send_byte(8'd2, 0); send_byte(8'h44, 0); send_byte(8'h49, 0); send_byte(8'h8C, 0);
    checks++; if (load_error !== 1'b1 || cpu_reset !== 1'b1 || bus.load_ready !== 1'b0) begin errors++; $display("FAIL chk_bad err %b cpu_reset %b ready %b want 1 1 0", load_error, cpu_reset, bus.load_ready); end
    run_req = 1'b1;
    repeat (3) tick();
    run_req = 1'b0;
    bus.pc = 8'h00; #1;
    checks++; if (cpu_reset !== 1'b1 || load_error !== 1'b1 || bus.instruction !== 8'h00) begin errors++; $display("FAIL chk_sticky cpu_reset %b err %b instr %h want 1 1 00", cpu_reset, load_error, bus.instruction); end
    pulse_start();
    checks++; if (load_error !== 1'b0) begin errors++; $display("FAIL chk_clear err %b want 0", load_error); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_load();
    test_gapped();
    test_full_depth();
    test_abort();
    test_reset_midload();
`ifdef CHECKSUM_EN
    test_checksum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
